// File: rtl/loader_pkg.sv
// Shared types and helpers for the BIOS stream loader: FSM states, source
// select encodings and lane-count arithmetic.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        R_ISSUE,
        R_CAPT,
        S_WAIT,
        WRITE,
        DONE
    } state_t;

    localparam logic SRC_ROM   = 1'b0;
    localparam logic SRC_IOCTL = 1'b1;

    // Bytes per target word.
    function automatic int lanes(input int dw_out);
        return dw_out / 8;
    endfunction

    // Width of a lane index; a single-lane word still gets a 1-bit counter.
    function automatic int lane_width(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/word_packer.sv
// Byte-to-word assembly register: each load writes one byte into the lane
// selected by i_lane, in little- or big-endian lane order.
module word_packer
    import loader_pkg::*;
#(
    parameter  int DW_OUT     = 16,
    parameter  bit BIG_ENDIAN = 1'b0,
    localparam int R          = lanes(DW_OUT),
    localparam int LW         = lane_width(R)
) (
    input  logic              i_clk_sys,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [LW-1:0]     i_lane,
    input  logic [7:0]        i_byte_in,
    output logic [DW_OUT-1:0] o_word
);

    logic [DW_OUT-1:0] r_word;

    always_ff @(posedge i_clk_sys) begin
        // NOTE: the word drives o_tgt_din directly, so it is reset to keep every
        // loader output at 0 after reset.
        if (i_reset) begin
            r_word <= '0;
        end else if (i_load) begin
            for (int l = 0; l < R; l++) begin
                // NOTE: non-blocking so this register updates in step with the FSM.
                if (i_lane == LW'(l)) begin
                    r_word[8*(BIG_ENDIAN ? (R-1-l) : l) +: 8] <= i_byte_in;
                end
            end
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/bios_stream_loader.sv
// Boot-image loader: pulls bytes from ROM or the HPS ioctl stream, packs them
// into target words and writes them to consecutive addresses under handshake.
module bios_stream_loader
    import loader_pkg::*;
#(
    parameter int DW_OUT     = 16,
    parameter int AW_OUT     = 13,
    parameter int WORDS      = 8192,
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int AW_ROM     = 14
) (
    input  logic              i_clk_sys,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_src_sel,
    output logic              o_rom_ce,
    output logic [AW_ROM-1:0] o_rom_addr,
    input  logic [7:0]        i_rom_data,
    input  logic              i_ioctl_download,
    input  logic              i_ioctl_wr,
    input  logic [7:0]        i_ioctl_dout,
    output logic              o_ioctl_wait,
    input  logic              i_tgt_req,
    output logic              o_tgt_wr,
    output logic [AW_OUT-1:0] o_tgt_addr,
    output logic [DW_OUT-1:0] o_tgt_din,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    localparam int R    = lanes(DW_OUT);
    localparam int LW   = lane_width(R);
    localparam int WC_W = AW_OUT + 1;
    localparam int PW   = WC_W + 4;

    localparam logic [WC_W-1:0] WORDS_C   = WC_W'(WORDS);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS - 1);
    localparam logic [LW-1:0]   LAST_LANE = LW'(R - 1);

    state_t              r_state, w_state_nx;
    logic                r_src, w_src_nx;
    logic [WC_W-1:0]     r_word_cnt, w_word_cnt_nx;
    logic [LW-1:0]       r_lane, w_lane_nx;
    logic                r_rom_ce, w_rom_ce_nx;
    logic [AW_ROM-1:0]   r_rom_addr, w_rom_addr_nx;
    logic                r_tgt_wr, w_tgt_wr_nx;
    logic [AW_OUT-1:0]   r_tgt_addr, w_tgt_addr_nx;
    logic                r_busy, w_busy_nx;
    logic                r_done, w_done_nx;
    logic                r_error, w_error_nx;
    logic                r_absorb, w_absorb_nx;
    logic                r_dl_d;
    logic                w_load;
    logic [7:0]          w_byte;
    logic                w_last_lane;
    logic                w_dl_fall;
    logic [DW_OUT-1:0]   w_word;

    function automatic logic [AW_ROM-1:0] rom_byte_addr(input logic [WC_W-1:0] cnt,
                                                        input logic [LW-1:0]   lane);
        logic [PW-1:0] full;
        full = PW'(cnt) * PW'(R) + PW'(lane);
        return AW_ROM'(full);
    endfunction

    assign w_last_lane = (r_lane == LAST_LANE);
    assign w_dl_fall   = r_dl_d & ~i_ioctl_download;

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_src      <= SRC_ROM;
            r_word_cnt <= '0;
            r_lane     <= '0;
            r_rom_ce   <= 1'b0;
            r_rom_addr <= '0;
            r_tgt_wr   <= 1'b0;
            r_tgt_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_absorb   <= 1'b0;
            r_dl_d     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_src      <= w_src_nx;
            r_word_cnt <= w_word_cnt_nx;
            r_lane     <= w_lane_nx;
            r_rom_ce   <= w_rom_ce_nx;
            r_rom_addr <= w_rom_addr_nx;
            r_tgt_wr   <= w_tgt_wr_nx;
            r_tgt_addr <= w_tgt_addr_nx;
            r_busy     <= w_busy_nx;
            r_done     <= w_done_nx;
            r_error    <= w_error_nx;
            r_absorb   <= w_absorb_nx;
            r_dl_d     <= i_ioctl_download;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets its default first so no path infers a latch.
        w_state_nx    = r_state;
        w_src_nx      = r_src;
        w_word_cnt_nx = r_word_cnt;
        w_lane_nx     = r_lane;
        w_rom_ce_nx   = 1'b0;
        w_rom_addr_nx = r_rom_addr;
        w_tgt_wr_nx   = r_tgt_wr;
        w_tgt_addr_nx = r_tgt_addr;
        w_busy_nx     = r_busy;
        w_done_nx     = r_done;
        w_error_nx    = r_error;
        w_absorb_nx   = r_absorb;
        w_load        = 1'b0;
        w_byte        = i_rom_data;

        case (r_state)
            IDLE, DONE: begin
                // After a complete ioctl image, trailing bytes are an overflow.
                if (r_state == DONE && r_absorb) begin
                    if (i_ioctl_wr) w_error_nx = 1'b1;
                    if (!i_ioctl_download) w_absorb_nx = 1'b0;
                end
                if (i_start) begin
                    w_src_nx      = i_src_sel;
                    w_word_cnt_nx = '0;
                    w_lane_nx     = '0;
                    w_busy_nx     = 1'b1;
                    w_done_nx     = 1'b0;
                    w_error_nx    = 1'b0;
                    w_absorb_nx   = 1'b0;
                    if (i_src_sel == SRC_ROM) begin
                        w_state_nx    = R_ISSUE;
                        w_rom_ce_nx   = 1'b1;
                        w_rom_addr_nx = '0;
                    end else begin
                        w_state_nx = S_WAIT;
                    end
                end
            end
            R_ISSUE: w_state_nx = R_CAPT;
            R_CAPT: begin
                w_load = 1'b1;
                if (w_last_lane) begin
                    w_state_nx    = WRITE;
                    w_tgt_wr_nx   = 1'b1;
                    w_tgt_addr_nx = r_word_cnt[AW_OUT-1:0];
                end else begin
                    w_lane_nx     = r_lane + LW'(1);
                    w_state_nx    = R_ISSUE;
                    w_rom_ce_nx   = 1'b1;
                    w_rom_addr_nx = rom_byte_addr(r_word_cnt, r_lane + LW'(1));
                end
            end
            S_WAIT: begin
                if (w_dl_fall && (r_word_cnt < WORDS_C || r_lane != '0)) begin
                    w_state_nx = DONE;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                    w_error_nx = 1'b1;
                end else if (i_ioctl_wr) begin
                    w_load = 1'b1;
                    w_byte = i_ioctl_dout;
                    if (w_last_lane) begin
                        w_state_nx    = WRITE;
                        w_tgt_wr_nx   = 1'b1;
                        w_tgt_addr_nx = r_word_cnt[AW_OUT-1:0];
                    end else begin
                        w_lane_nx = r_lane + LW'(1);
                    end
                end
            end
            WRITE: begin
                if (r_src == SRC_IOCTL && i_ioctl_wr) w_error_nx = 1'b1;
                if (i_tgt_req) begin
                    w_tgt_wr_nx   = 1'b0;
                    w_word_cnt_nx = r_word_cnt + WC_W'(1);
                    w_lane_nx     = '0;
                    if (r_word_cnt == LAST_WORD) begin
                        w_state_nx  = DONE;
                        w_busy_nx   = 1'b0;
                        w_done_nx   = 1'b1;
                        w_absorb_nx = (r_src == SRC_IOCTL);
                    end else if (r_src == SRC_ROM) begin
                        w_state_nx    = R_ISSUE;
                        w_rom_ce_nx   = 1'b1;
                        w_rom_addr_nx = rom_byte_addr(r_word_cnt + WC_W'(1), LW'(0));
                    end else begin
                        w_state_nx = S_WAIT;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    word_packer #(
        .DW_OUT    (DW_OUT),
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_packer (
        .i_clk_sys(i_clk_sys),
        .i_reset  (i_reset),
        .i_load   (w_load),
        .i_lane   (r_lane),
        .i_byte_in(w_byte),
        .o_word   (w_word)
    );

    assign o_rom_ce     = r_rom_ce;
    assign o_rom_addr   = r_rom_addr;
    assign o_ioctl_wait = (r_state == WRITE) && (r_src == SRC_IOCTL);
    assign o_tgt_wr     = r_tgt_wr;
    assign o_tgt_addr   = r_tgt_addr;
    assign o_tgt_din    = w_word;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;

endmodule

// File: doc/bios_stream_loader.md
# bios_stream_loader

Parametrised boot-image loader between an image source and the system core's BIOS write port. It pulls bytes from either an on-chip ROM (fixed read latency) or the HPS ioctl download stream, packs them into target-width words with selectable byte order, and writes them to consecutive target addresses under a request/write handshake. It raises `done` once a full image is written, and `error` on a short or overflowing download. The core holds reset until `done` is high.

## Interface
- `DW_OUT`, 16: target word width; a multiple of 8, from 8 to 64. R = DW_OUT/8 bytes per word.
- `AW_OUT`, 13: target address width.
- `WORDS`, 8192: image length in words. Must be ≤ 2^AW_OUT.
- `BIG_ENDIAN`, 0: 0 = first byte goes to bits [7:0]; 1 = first byte goes to the MSB lane.
- `AW_ROM`, 14: ROM byte-address width. Must be ≥ clog2(WORDS*R).
- `clk_sys` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a load. Ignored while `busy`.
- `src_sel` in 1: 0 = ROM, 1 = ioctl. Sampled on `start`.
- `rom_ce` out 1, `rom_addr` out AW_ROM: ROM read strobe and byte address.
- `rom_data` in 8: valid on the cycle after `rom_ce`.
- `ioctl_download` in 1, `ioctl_wr` in 1, `ioctl_dout` in 8: HPS byte stream.
- `ioctl_wait` out 1: stalls the HPS stream.
- `tgt_req` in 1: target ready (level).
- `tgt_wr` out 1, `tgt_addr` out AW_OUT, `tgt_din` out DW_OUT: target write.
- `busy`, `done`, `error` out 1: status levels.

## Operation
- Reset values: every output is 0. State is IDLE. Word and byte counters are 0.
- Width rules:
  - Word counter is AW_OUT+1 bits.
  - Byte lane counter is clog2(R) bits, minimum 1.
  - `rom_addr` = word_cnt*R + lane, truncated to AW_ROM.
- `start` in IDLE:
  - Clears `done`, `error` and the counters.
  - Sets `busy`.
  - Goes to R_ISSUE (ROM) or S_WAIT (ioctl).
- ROM path:
  - R_ISSUE: `rom_ce`=1 for one cycle → R_CAPT.
  - R_CAPT: latch `rom_data` into lane `lane`. If lane = R-1 → WRITE, else lane++ → R_ISSUE.
- ioctl path:
  - S_WAIT: on `ioctl_wr`, latch `ioctl_dout` into lane `lane`. If lane = R-1 → WRITE, else lane++.
  - If `ioctl_download` falls in S_WAIT with word_cnt < WORDS or lane ≠ 0 → DONE with `error`=1.
  - `ioctl_wait`=1 in WRITE while src=ioctl. It is 0 otherwise.
- WRITE:
  - `tgt_wr`=1, with `tgt_addr`=word_cnt[AW_OUT-1:0] and `tgt_din`=packed word. All three are held stable until accepted.
  - Accept occurs on a cycle with `tgt_wr`=1 and `tgt_req`=1. On accept: word_cnt++, lane=0.
  - Next state after accept: if word_cnt+1 = WORDS → DONE, else back to R_ISSUE or S_WAIT.
- DONE:
  - `busy`=0 and `done`=1.
  - If src=ioctl, ioctl bytes are absorbed and dropped until `ioctl_download` falls. Any byte received after WORDS words sets `error` (overflow). `done` stays 1.
  - Returns to IDLE on `start`. `done` and `error` hold until then.
- Reset mid-load: immediate return to IDLE with all outputs 0. No partial-write completion.
- Simultaneous events:
  - `ioctl_wr` in WRITE is a protocol violation. The byte is dropped and `error` is set.
  - `start` in DONE begins a new load on the same cycle the status flags clear.

## Timing
- ROM read latency: 1 cycle.
- ROM mode with `tgt_req` held high: one word per 2R+1 cycles. For R=2 this is 5 cycles per word.
- `start` to first `rom_ce`: 1 cycle.
- Final accept to `done`=1: 1 cycle.
- `tgt_wr` deasserts the cycle after accept.
- ioctl mode: R `ioctl_wr` strobes produce one write. `ioctl_wait` rises the cycle after the R-th byte and falls the cycle after accept.
- Registered outputs: `tgt_*`, `rom_*`, `busy`, `done` and `error` are all registered. `ioctl_wait` is a decode of the registered state.

## Structure
- Package `loader_pkg`:
  - State enum: IDLE, R_ISSUE, R_CAPT, S_WAIT, WRITE, DONE.
  - Constants SRC_ROM=0 and SRC_IOCTL=1.
  - Function `lanes(DW_OUT)`.
- Sub-module `word_packer`:
  - Parameters DW_OUT and BIG_ENDIAN.
  - Inputs: clk_sys, reset, `load`, `lane`, `byte_in`.
  - Output: `word`.
  - Lane write maps to bit offset 8*lane (LE) or 8*(R-1-lane) (BE).
- FSM, counters and handshake live in `bios_stream_loader`.

## Test plan
- ROM, DW_OUT=16, WORDS=4, LE; ROM bytes 00..07; `tgt_req`=1 → writes addr 0..3 = 0100, 0302, 0504, 0706. Consecutive writes are 5 cycles apart. `done` rises 1 cycle after the last accept.
- Same stimulus with BIG_ENDIAN=1, DW_OUT=32, WORDS=2 → 00010203 at addr 0 and 04050607 at addr 1.
- Backpressure: `tgt_req` low for 10 cycles during the word-1 write → `tgt_wr`/`tgt_addr`/`tgt_din` are held constant. Exactly one accept for word 1, with data unchanged.
- ioctl, DW_OUT=16, WORDS=3; 6 bytes AA..FF with `ioctl_wr` gaps → 3 writes. `ioctl_wait` is high only during WRITE. `error`=0.
- ioctl short: `ioctl_download` falls after 3 bytes with WORDS=3 → one write, then DONE with `error`=1. Overflow: a 7th byte → `error`=1 and `done`=1.
- `reset` asserted in R_CAPT mid-word → next cycle all outputs 0. A following `start` restarts at addr 0 with a fresh byte 0.
